// File: rtl/riscv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_ctrl_pkg
// Shared definitions for the multicycle RV32I control FSM: opcode values,
// the 4-bit state encoding, datapath mux-select codes and an immediate-format
// helper used by both the FSM and anyone decoding its debug state.
// ---------------------------------------------------------------------------
package riscv_ctrl_pkg;

    // RV32I major opcodes (IR[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Controller states, exported on state_o for debug
    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXE_R  = 4'd3,
        ST_EXE_I  = 4'd4,
        ST_ALUWB  = 4'd5,
        ST_MEMADR = 4'd6,
        ST_MEMRD  = 4'd7,
        ST_MEMWB  = 4'd8,
        ST_MEMWR  = 4'd9,
        ST_BRANCH = 4'd10,
        ST_JAL    = 4'd11,
        ST_JALR   = 4'd12,
        ST_LUIWB  = 4'd13,
        ST_TRAP   = 4'd14
    } state_e;

    // ALU operand A select
    localparam logic [1:0] A_RS1   = 2'b00;
    localparam logic [1:0] A_PC    = 2'b01;
    localparam logic [1:0] A_OLDPC = 2'b10;

    // ALU operand B select
    localparam logic [1:0] B_RS2  = 2'b00;
    localparam logic [1:0] B_IMM  = 2'b01;
    localparam logic [1:0] B_FOUR = 2'b10;

    // ALU operation class
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    // Immediate format
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Register-file write-back source
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MDR    = 2'b01;
    localparam logic [1:0] RES_IMM    = 2'b10;
    localparam logic [1:0] RES_PC     = 2'b11;

    // Immediate format purely from the opcode; unknown opcodes fall back to I
    function automatic logic [2:0] immSrcFor(input logic [6:0] op);
        logic [2:0] imm;
        imm = IMM_I;
        case (op)
            OP_STORE:         imm = IMM_S;
            OP_BRANCH:        imm = IMM_B;
            OP_JAL:           imm = IMM_J;
            OP_LUI, OP_AUIPC: imm = IMM_U;
            default:          imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// ---------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive memory wait cycles and flags the cycle in which the
// count reaches WAIT_LIMIT. WAIT_LIMIT = 0 disables the watchdog.
// Ports:
//   clk        in  clock
//   rst_n      in  async active-low reset
//   clr_i      in  clear the count (no request, or request completed)
//   inc_i      in  a wait cycle is in progress
//   timeout_o  out this wait cycle is the WAIT_LIMIT-th in a row
// ---------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic timeout_o
);

    localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LAST = (WAIT_LIMIT > 0) ? CW'(WAIT_LIMIT - 1) : '0;
    localparam bit ENABLED = (WAIT_LIMIT > 0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // The count holds the number of wait cycles already completed, so the
    // current wait cycle is the limit-th one when count_q equals LIMIT-1.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && ENABLED) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = ENABLED && inc_i && (count_q == LAST);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
// Control FSM for a multicycle RV32I datapath with one shared instruction /
// data memory port. Sequences fetch, decode, execute, memory and write-back,
// drives all datapath enables and mux selects, runs a req/ready handshake
// guarded by a wait watchdog, and traps (sticky) on illegal opcode or timeout.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   opcode[6:0]          IR[6:0], valid from DECODE onward
//   branch_cond          comparator result, used only in BRANCH
//   mem_ready            transfer completes in a cycle with mem_req=1
//   mem_req, mem_we      memory request / store
//   addr_sel             memory address: 0 PC, 1 ALUOut
//   ir_we, oldpc_we      load IR+MDR / capture OldPC
//   pc_we, pc_src        PC write enable, source 0 ALU / 1 ALUOut
//   reg_we               register file write
//   a_sel, b_sel, alu_op ALU operand selects and operation class
//   imm_src[2:0]         immediate format, from opcode in every state
//   result_src[1:0]      write-back source
//   retire               last cycle of a completed instruction
//   trap                 sticky trap indication
//   state_o[3:0]         current state (debug)
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic       branch_cond,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       ir_we,
    output logic       oldpc_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic       reg_we,
    output logic [1:0] a_sel,
    output logic [1:0] b_sel,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       retire,
    output logic       trap,
    output logic [3:0] state_o
);

    state_e state_q;
    state_e state_d;
    logic   timerClr;
    logic   timerInc;
    logic   timeout;

    // A wait cycle is any cycle with a pending request and no ready
    assign timerInc = mem_req && !mem_ready;
    assign timerClr = !mem_req || mem_ready;

    mem_wait_timer #(
        .WAIT_LIMIT(WAIT_LIMIT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (timerClr),
        .inc_i    (timerInc),
        .timeout_o(timeout)
    );

    // State register; async reset drops every output on the same instant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In memory states ready beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)    state_d = ST_DECODE;
                else if (timeout) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_R:               state_d = ST_EXE_R;
                    OP_I:               state_d = ST_EXE_I;
                    OP_LOAD, OP_STORE:  state_d = ST_MEMADR;
                    OP_BRANCH:          state_d = ST_BRANCH;
                    OP_JAL:             state_d = ST_JAL;
                    OP_JALR:            state_d = ST_JALR;
                    OP_LUI:             state_d = ST_LUIWB;
                    OP_AUIPC:           state_d = ST_ALUWB;
                    default:            state_d = ST_TRAP;
                endcase
            end
            ST_EXE_R, ST_EXE_I: state_d = ST_ALUWB;
            ST_MEMADR: state_d = (opcode == OP_LOAD) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (mem_ready)    state_d = ST_MEMWB;
                else if (timeout) state_d = ST_TRAP;
            end
            ST_MEMWR: begin
                if (mem_ready)    state_d = ST_FETCH;
                else if (timeout) state_d = ST_TRAP;
            end
            ST_ALUWB, ST_MEMWB, ST_BRANCH, ST_JAL, ST_JALR, ST_LUIWB:
                state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_TRAP;
        endcase
    end

    // Output decode: one case on state. Enables tied to a transfer only fire
    // on the ready cycle, so a timeout cycle never asserts any of them.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_we      = 1'b0;
        oldpc_we   = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        reg_we     = 1'b0;
        a_sel      = A_RS1;
        b_sel      = B_RS2;
        alu_op     = ALU_ADD;
        result_src = RES_ALUOUT;
        retire     = 1'b0;
        trap       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                a_sel    = A_PC;
                b_sel    = B_FOUR;
                ir_we    = mem_ready;
                oldpc_we = mem_ready;
                pc_we    = mem_ready;
            end
            ST_DECODE: begin
                a_sel = A_OLDPC;
                b_sel = B_IMM;
            end
            ST_EXE_R:  alu_op = ALU_RFUNCT;
            ST_EXE_I: begin
                b_sel  = B_IMM;
                alu_op = ALU_IFUNCT;
            end
            ST_ALUWB: begin
                reg_we = 1'b1;
                retire = 1'b1;
            end
            ST_MEMADR: b_sel = B_IMM;
            ST_MEMRD: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
            end
            ST_MEMWB: begin
                reg_we     = 1'b1;
                result_src = RES_MDR;
                retire     = 1'b1;
            end
            ST_MEMWR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                addr_sel = 1'b1;
                retire   = mem_ready;
            end
            ST_BRANCH: begin
                alu_op = ALU_SUB;
                pc_we  = branch_cond;
                pc_src = branch_cond;
                retire = 1'b1;
            end
            ST_JAL: begin
                pc_we      = 1'b1;
                pc_src     = 1'b1;
                reg_we     = 1'b1;
                result_src = RES_PC;
                retire     = 1'b1;
            end
            ST_JALR: begin
                b_sel      = B_IMM;
                pc_we      = 1'b1;
                reg_we     = 1'b1;
                result_src = RES_PC;
                retire     = 1'b1;
            end
            ST_LUIWB: begin
                reg_we     = 1'b1;
                result_src = RES_IMM;
                retire     = 1'b1;
            end
            ST_TRAP:  trap = 1'b1;
            default: ;
        endcase
    end

    assign imm_src = immSrcFor(opcode);
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
// Scoreboard bench: the stimulus side walks each instruction through the
// phase list implied by its opcode, pushes the expected per-cycle outputs,
// and a monitor on the falling edge pops and compares every cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

    localparam int WAIT_LIMIT = 4;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       memReq;
        logic       memWe;
        logic       addrSel;
        logic       irWe;
        logic       oldpcWe;
        logic       pcWe;
        logic       pcSrc;
        logic       regWe;
        logic [1:0] aSel;
        logic [1:0] bSel;
        logic [1:0] aluOp;
        logic [2:0] immSrc;
        logic [1:0] resultSrc;
        logic       retire;
        logic       trap;
    } outVec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       branch_cond;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_we, oldpc_we, pc_we, pc_src, reg_we;
    logic [1:0] a_sel, b_sel, alu_op, result_src;
    logic [2:0] imm_src;
    logic       retire, trap;
    logic [3:0] state_o;

    outVec_t expQ[$];
    string   tagQ[$];
    int      vectors = 0;
    int      miscompares = 0;
    logic [6:0] legalOps [9] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                 OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_cond(branch_cond),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .ir_we(ir_we), .oldpc_we(oldpc_we), .pc_we(pc_we),
        .pc_src(pc_src), .reg_we(reg_we), .a_sel(a_sel), .b_sel(b_sel),
        .alu_op(alu_op), .imm_src(imm_src), .result_src(result_src),
        .retire(retire), .trap(trap), .state_o(state_o)
    );

    // Immediate format of an instruction class
    function automatic logic [2:0] immFor(input logic [6:0] op);
        if (op == OP_STORE)                  return 3'b001;
        if (op == OP_BRANCH)                 return 3'b010;
        if (op == OP_JAL)                    return 3'b011;
        if (op == OP_LUI || op == OP_AUIPC)  return 3'b100;
        return 3'b000;
    endfunction

    function automatic bit isLegal(input logic [6:0] op);
        foreach (legalOps[i]) if (legalOps[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // What the datapath controls must look like during a named phase
    function automatic outVec_t expectFor(input string ph, input logic [6:0] op,
                                          input logic ready, input logic cond);
        outVec_t v;
        v = '0;
        v.immSrc = immFor(op);
        if (ph == "FETCH") begin
            v.memReq = 1; v.aSel = 2'b01; v.bSel = 2'b10;
            v.irWe = ready; v.oldpcWe = ready; v.pcWe = ready;
        end else if (ph == "DECODE") begin
            v.aSel = 2'b10; v.bSel = 2'b01;
        end else if (ph == "EXE_R") begin
            v.aluOp = 2'b10;
        end else if (ph == "EXE_I") begin
            v.bSel = 2'b01; v.aluOp = 2'b11;
        end else if (ph == "ALUWB") begin
            v.regWe = 1; v.retire = 1;
        end else if (ph == "MEMADR") begin
            v.bSel = 2'b01;
        end else if (ph == "MEMRD") begin
            v.memReq = 1; v.addrSel = 1;
        end else if (ph == "MEMWB") begin
            v.regWe = 1; v.resultSrc = 2'b01; v.retire = 1;
        end else if (ph == "MEMWR") begin
            v.memReq = 1; v.memWe = 1; v.addrSel = 1; v.retire = ready;
        end else if (ph == "BRANCH") begin
            v.aluOp = 2'b01; v.pcWe = cond; v.pcSrc = cond; v.retire = 1;
        end else if (ph == "JAL") begin
            v.pcWe = 1; v.pcSrc = 1; v.regWe = 1; v.resultSrc = 2'b11; v.retire = 1;
        end else if (ph == "JALR") begin
            v.bSel = 2'b01; v.pcWe = 1; v.regWe = 1; v.resultSrc = 2'b11; v.retire = 1;
        end else if (ph == "LUIWB") begin
            v.regWe = 1; v.resultSrc = 2'b10; v.retire = 1;
        end else if (ph == "TRAP") begin
            v.trap = 1;
        end
        return v;
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue the
    // outputs expected for that cycle
    task automatic applyStimulus(input logic [6:0] op, input logic ready,
                                 input logic cond, input logic rstVal, input string ph);
        @(posedge clk);
        #1;
        rst_n       = rstVal;
        opcode      = op;
        mem_ready   = ready;
        branch_cond = cond;
        expQ.push_back(expectFor(ph, op, ready, cond));
        tagQ.push_back(ph);
    endtask

    // Compare one sampled output vector against its expectation
    task automatic checkOutput(input outVec_t exp, input string tag);
        outVec_t got;
        got = '{memReq: mem_req, memWe: mem_we, addrSel: addr_sel, irWe: ir_we,
                oldpcWe: oldpc_we, pcWe: pc_we, pcSrc: pc_src, regWe: reg_we,
                aSel: a_sel, bSel: b_sel, aluOp: alu_op, immSrc: imm_src,
                resultSrc: result_src, retire: retire, trap: trap};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    // Monitor: one queued expectation per cycle, sampled on the falling edge
    always @(negedge clk) begin
        if (expQ.size() != 0) checkOutput(expQ.pop_front(), tagQ.pop_front());
    end

    // Two cycles in reset (outputs must be idle at once), then one IDLE cycle
    task automatic doReset(input logic [6:0] op);
        applyStimulus(op, 1'($urandom), 1'($urandom), 1'b0, "RESET");
        applyStimulus(op, 1'($urandom), 1'($urandom), 1'b0, "RESET");
        applyStimulus(op, 1'($urandom), 1'($urandom), 1'b1, "IDLE");
    endtask

    task automatic trapCycles(input logic [6:0] op, input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(op, 1'($urandom), 1'($urandom), 1'b1, "TRAP");
    endtask

    // Run one instruction; memory phases get the given number of wait cycles
    // before ready. Returns trapped=1 when the FSM is headed into TRAP.
    task automatic runInstr(input logic [6:0] op, input logic cond,
                            input int fetchWaits, input int memWaits, output bit trapped);
        string phases[$];
        trapped = 0;
        case (op)
            OP_R:      phases = '{"FETCH", "DECODE", "EXE_R", "ALUWB"};
            OP_I:      phases = '{"FETCH", "DECODE", "EXE_I", "ALUWB"};
            OP_LOAD:   phases = '{"FETCH", "DECODE", "MEMADR", "MEMRD", "MEMWB"};
            OP_STORE:  phases = '{"FETCH", "DECODE", "MEMADR", "MEMWR"};
            OP_BRANCH: phases = '{"FETCH", "DECODE", "BRANCH"};
            OP_JAL:    phases = '{"FETCH", "DECODE", "JAL"};
            OP_JALR:   phases = '{"FETCH", "DECODE", "JALR"};
            OP_LUI:    phases = '{"FETCH", "DECODE", "LUIWB"};
            OP_AUIPC:  phases = '{"FETCH", "DECODE", "ALUWB"};
            default:   phases = '{"FETCH", "DECODE", "TRAP"};
        endcase
        for (int p = 0; p < phases.size(); p++) begin
            string ph;
            ph = phases[p];
            if (ph == "TRAP") begin
                trapped = 1;
                return;
            end
            if (ph == "FETCH" || ph == "MEMRD" || ph == "MEMWR") begin
                int w;
                w = (ph == "FETCH") ? fetchWaits : memWaits;
                for (int k = 0; k < w; k++) begin
                    applyStimulus(op, 1'b0, cond, 1'b1, ph);
                    if (WAIT_LIMIT != 0 && k + 1 == WAIT_LIMIT) begin
                        trapped = 1;
                        return;
                    end
                end
                applyStimulus(op, 1'b1, cond, 1'b1, ph);
            end else begin
                applyStimulus(op, 1'($urandom), cond, 1'b1, ph);
            end
        end
    endtask

    initial begin
        bit t;
        logic [6:0] op;
        rst_n = 1'b0; opcode = OP_R; mem_ready = 1'b0; branch_cond = 1'b0;
        doReset(OP_R);

        // Directed instructions
        runInstr(OP_R,      1'b0, 0, 0, t);
        runInstr(OP_LOAD,   1'b0, 0, 3, t);
        runInstr(OP_BRANCH, 1'b1, 0, 0, t);
        runInstr(OP_BRANCH, 1'b0, 0, 0, t);
        runInstr(OP_JALR,   1'b0, 0, 0, t);
        runInstr(OP_STORE,  1'b0, 1, 2, t);
        runInstr(OP_JAL,    1'b0, 0, 0, t);
        runInstr(OP_LUI,    1'b0, 0, 0, t);
        runInstr(OP_AUIPC,  1'b0, 1, 0, t);
        runInstr(OP_I,      1'b0, 0, 0, t);

        // Illegal opcode: sticky trap until reset
        runInstr(7'b1111111, 1'b0, 0, 0, t);
        trapCycles(7'b1111111, 10);
        doReset(OP_R);

        // Fetch watchdog
        runInstr(OP_R, 1'b0, WAIT_LIMIT, 0, t);
        trapCycles(OP_R, 3);
        doReset(OP_R);

        // Reset in the middle of a pending fetch
        applyStimulus(OP_R, 1'b0, 1'b0, 1'b1, "FETCH");
        applyStimulus(OP_R, 1'b0, 1'b0, 1'b1, "FETCH");
        doReset(OP_R);

        // Random instruction stream with occasional illegal ops and timeouts
        for (int n = 0; n < 80; n++) begin
            int fw, mw;
            if ($urandom_range(0, 19) == 0) begin
                op = 7'($urandom);
                if (isLegal(op)) op = 7'b1111111;
            end else begin
                op = legalOps[$urandom_range(0, 8)];
            end
            fw = ($urandom_range(0, 14) == 0) ? WAIT_LIMIT + 1 : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 14) == 0) ? WAIT_LIMIT     : int'($urandom_range(0, 3));
            runInstr(op, 1'($urandom), fw, mw, t);
            if (t) begin
                trapCycles(op, int'($urandom_range(1, 4)));
                doReset(op);
            end
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
